// File: rtl/cpu_loader_pkg.sv
// Shared definitions for the CPU memory image loader: FSM encoding,
// frame layout constants and a state classification helper.
package cpu_loader_pkg;

  localparam int BYTE_W    = 8;
  localparam int WORD_W    = 16;
  localparam int LEN_BYTES = 2;  // word count, big-endian
  localparam int CHK_BYTES = 1;  // 8-bit additive checksum over data bytes

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LEN_HI = 4'd1,
    S_LEN_LO = 4'd2,
    S_DAT_HI = 4'd3,
    S_DAT_LO = 4'd4,
    S_WRITE  = 4'd5,
    S_CHK    = 4'd6,
    S_DONE   = 4'd7,
    S_ERR    = 4'd8
  } state_t;

  // True while a frame is being received (the CPU is held in stall).
  function automatic logic in_frame(state_t s);
    return (s inside {S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO, S_WRITE, S_CHK});
  endfunction

  // True in the states from which a start pulse may arm the loader.
  function automatic logic can_arm(state_t s);
    return (s inside {S_IDLE, S_DONE, S_ERR});
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte idle counter. Counts enabled cycles since the last clear and
// saturates at LIMIT, where expired stays high until the next clear.
module loader_timeout #(
  parameter int LIMIT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

  logic [W-1:0] cnt;

  // Idle-cycle counter: clear wins, then count up to LIMIT and hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LIMIT_W)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = (cnt == LIMIT_W);

endmodule

// File: rtl/cpu_mem_loader.sv
// Loads a length-prefixed, checksummed byte stream into CPU word memory.
// Frame: LEN_HI LEN_LO, then N words (high byte first), then checksum byte.
// Handshake: rx_valid is a one-cycle strobe with no back-pressure; every
// strobe seen in LEN_HI..CHK is consumed that cycle (including in WRITE,
// where it becomes the next high byte, or the checksum after the last word).
// state_dbg mirrors the FSM state register for checkers and debug.
module cpu_mem_loader
  import cpu_loader_pkg::*;
#(
  parameter int          DEPTH     = 512,
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          TIMEOUT   = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        we,
  output logic [15:0] d_addr,
  output logic [15:0] wrt_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  state_dbg
);

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state, state_next;
  logic [7:0]  len_hi, hi_byte, sum;
  logic [15:0] len, idx;
  logic [15:0] n_word;
  logic        start_ok, byte_ok, len_bad, last_word, sum_ok, expired;
  logic        we_d, busy_d, done_d, err_d;

  assign start_ok  = start && can_arm(state);
  assign byte_ok   = rx_valid && in_frame(state);
  assign n_word    = {len_hi, rx_data};
  assign len_bad   = (n_word == 16'd0) || ({1'b0, n_word} > DEPTH_W);
  assign last_word = ((idx + 16'd1) == len);
  assign sum_ok    = (rx_data == sum);
  assign state_dbg = state;

  loader_timeout #(.LIMIT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!in_frame(state) || rx_valid),
    .enable  (in_frame(state)),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic: frame states move only on rx_valid or on timeout.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_next = S_LEN_HI;
      S_LEN_HI: begin
        if (rx_valid)     state_next = S_LEN_LO;
        else if (expired) state_next = S_ERR;
      end
      S_LEN_LO: begin
        if (rx_valid)     state_next = len_bad ? S_ERR : S_DAT_HI;
        else if (expired) state_next = S_ERR;
      end
      S_DAT_HI: begin
        if (rx_valid)     state_next = S_DAT_LO;
        else if (expired) state_next = S_ERR;
      end
      S_DAT_LO: begin
        if (rx_valid)     state_next = S_WRITE;
        else if (expired) state_next = S_ERR;
      end
      // A byte arriving during the write belongs to the following field.
      S_WRITE: begin
        if (last_word) begin
          if (rx_valid) state_next = sum_ok ? S_DONE : S_ERR;
          else          state_next = S_CHK;
        end else begin
          state_next = rx_valid ? S_DAT_LO : S_DAT_HI;
        end
      end
      S_CHK: begin
        if (rx_valid)     state_next = sum_ok ? S_DONE : S_ERR;
        else if (expired) state_next = S_ERR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode from the next state, so the flags register in step with it.
  always_comb begin
    we_d   = (state_next == S_WRITE);
    busy_d = in_frame(state_next);
    done_d = (state_next == S_DONE);
    err_d  = (state_next == S_ERR);
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we   <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      we   <= we_d;
      busy <= busy_d;
      done <= done_d;
      err  <= err_d;
    end
  end

  // Frame datapath: length, byte assembly, checksum, word index, write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_hi   <= '0;
      hi_byte  <= '0;
      sum      <= '0;
      len      <= '0;
      idx      <= '0;
      d_addr   <= '0;
      wrt_data <= '0;
    end else if (start_ok) begin
      idx <= '0;
      sum <= '0;
    end else begin
      if (state == S_WRITE) idx <= idx + 16'd1;
      if (byte_ok) begin
        case (state)
          S_LEN_HI: len_hi <= rx_data;
          S_LEN_LO: len    <= n_word;
          S_DAT_HI: begin
            hi_byte <= rx_data;
            sum     <= sum + rx_data;
          end
          S_DAT_LO: begin
            wrt_data <= {hi_byte, rx_data};
            d_addr   <= BASE_ADDR + idx;
            sum      <= sum + rx_data;
          end
          S_WRITE: begin
            if (!last_word) begin
              hi_byte <= rx_data;
              sum     <= sum + rx_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_mem_loader.sv
// Directed bench for cpu_mem_loader. Two instances share the stimulus: one at
// base address 0 and one at 16'hFFFE to exercise address wrap-around.
module tb_cpu_mem_loader;
  import cpu_loader_pkg::*;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start, rx_valid;
  logic [7:0]  rx_data;
  logic        we, busy, done, err;
  logic [15:0] d_addr, wrt_data;
  logic [3:0]  state_dbg;
  logic        we2, busy2, done2, err2;
  logic [15:0] d_addr2, wrt_data2;
  logic [3:0]  state_dbg2;

  cpu_mem_loader #(.DEPTH(DEPTH), .BASE_ADDR(16'h0000), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .we(we), .d_addr(d_addr), .wrt_data(wrt_data), .busy(busy), .done(done),
    .err(err), .state_dbg(state_dbg)
  );

  cpu_mem_loader #(.DEPTH(DEPTH), .BASE_ADDR(16'hFFFE), .TIMEOUT(TIMEOUT)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .we(we2), .d_addr(d_addr2), .wrt_data(wrt_data2), .busy(busy2), .done(done2),
    .err(err2), .state_dbg(state_dbg2)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];   // {addr, data} for dut
  logic [31:0] exp2_q[$];  // {addr, data} for dut_wrap
  int wr_cnt = 0;
  int wr_base;

  task automatic exp_wr(input int i, input logic [15:0] data);
    logic [15:0] a2;
    a2 = 16'hFFFE + 16'(i);
    exp_q.push_back({16'(i), data});
    exp2_q.push_back({a2, data});
  endtask

  always @(negedge clk) begin
    if (rst_n && we) begin
      wr_cnt++;
      check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("wr", {d_addr, wrt_data}, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && we2) begin
      check("wr2_expected", 32'(exp2_q.size() != 0), 32'd1);
      if (exp2_q.size() != 0) check("wr2", {d_addr2, wrt_data2}, exp2_q.pop_front());
    end
  end

  // ---------------- drivers ----------------
  logic [7:0] tx_q[$];

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Sends tx_q; gap = idle cycles between bytes (0 = back-to-back).
  task automatic send_bytes(input int gap);
    logic [7:0] b;
    while (tx_q.size() != 0) begin
      b = tx_q.pop_front();
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      if (gap > 0) begin
        @(negedge clk) rx_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
    end
    @(negedge clk) rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check("idle_wait", 32'(busy), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    logic [7:0] cs, hi, lo;
    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_we",    32'(we),        32'd0);
    check("rst_addr",  32'(d_addr),    32'd0);
    check("rst_data",  32'(wrt_data),  32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_done",  32'(done),      32'd0);
    check("rst_err",   32'(err),       32'd0);
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Stray byte while idle is ignored.
    tx_q = '{8'h55};
    send_bytes(1);
    check("idle_byte_state", 32'(state_dbg), 32'(S_IDLE));
    check("idle_byte_busy",  32'(busy),      32'd0);

    // Two-word image; checksum 12+34+AB+CD = 0x1BE -> 0xBE. Start mid-frame ignored.
    wr_base = wr_cnt;
    do_start();
    check("t1_busy",  32'(busy),      32'd1);
    check("t1_state", 32'(state_dbg), 32'(S_LEN_HI));
    exp_wr(0, 16'h1234);
    exp_wr(1, 16'hABCD);
    tx_q = '{8'h00, 8'h02, 8'h12, 8'h34};
    send_bytes(1);
    do_start();
    check("t1_start_ignored", 32'(state_dbg), 32'(S_DAT_HI));
    tx_q = '{8'hAB, 8'hCD, 8'hBE};
    send_bytes(1);
    wait_idle(50);
    check("t1_done",   32'(done),           32'd1);
    check("t1_err",    32'(err),            32'd0);
    check("t1_done2",  32'(done2),          32'd1);
    check("t1_writes", 32'(wr_cnt - wr_base), 32'd2);

    // Zero length -> error, and the new start clears done.
    wr_base = wr_cnt;
    do_start();
    check("t2_done_clr", 32'(done), 32'd0);
    check("t2_busy",     32'(busy), 32'd1);
    tx_q = '{8'h00, 8'h00};
    send_bytes(1);
    wait_idle(50);
    check("t2_err",    32'(err),  32'd1);
    check("t2_done",   32'(done), 32'd0);
    check("t2_writes", 32'(wr_cnt - wr_base), 32'd0);

    // Length DEPTH+1 -> error.
    wr_base = wr_cnt;
    do_start();
    check("t2b_err_clr", 32'(err), 32'd0);
    tx_q = '{8'h00, 8'h09};
    send_bytes(1);
    wait_idle(50);
    check("t2b_err",    32'(err), 32'd1);
    check("t2b_writes", 32'(wr_cnt - wr_base), 32'd0);

    // Bad checksum (good would be 0x46): word still written, then error.
    wr_base = wr_cnt;
    do_start();
    exp_wr(0, 16'h1234);
    tx_q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h00};
    send_bytes(1);
    wait_idle(50);
    check("t3_err",    32'(err),  32'd1);
    check("t3_done",   32'(done), 32'd0);
    check("t3_writes", 32'(wr_cnt - wr_base), 32'd1);

    // Silence after a high byte -> timeout error, no writes.
    wr_base = wr_cnt;
    do_start();
    tx_q = '{8'h00, 8'h02, 8'h12};
    send_bytes(0);
    repeat (TIMEOUT - 2) @(negedge clk);
    check("t4_busy_before", 32'(busy), 32'd1);
    check("t4_err_before",  32'(err),  32'd0);
    repeat (5) @(negedge clk);
    check("t4_err",    32'(err),  32'd1);
    check("t4_busy",   32'(busy), 32'd0);
    check("t4_writes", 32'(wr_cnt - wr_base), 32'd0);

    // Asynchronous reset after the first of two words, then a full frame.
    wr_base = wr_cnt;
    do_start();
    exp_wr(0, 16'h1234);
    tx_q = '{8'h00, 8'h02, 8'h12, 8'h34};
    send_bytes(1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_we",     32'(we),        32'd0);
    check("t5_addr",   32'(d_addr),    32'd0);
    check("t5_data",   32'(wrt_data),  32'd0);
    check("t5_busy",   32'(busy),      32'd0);
    check("t5_done",   32'(done),      32'd0);
    check("t5_err",    32'(err),       32'd0);
    check("t5_state",  32'(state_dbg), 32'(S_IDLE));
    check("t5_writes", 32'(wr_cnt - wr_base), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    wr_base = wr_cnt;
    do_start();
    exp_wr(0, 16'h1122);
    exp_wr(1, 16'h3344);
    tx_q = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    send_bytes(1);
    wait_idle(50);
    check("t5_done",     32'(done), 32'd1);
    check("t5_writes2",  32'(wr_cnt - wr_base), 32'd2);

    // Back-to-back bytes, N = DEPTH; words {10+i, 80+i}.
    wr_base = wr_cnt;
    do_start();
    cs = 8'h00;
    tx_q = '{8'h00, 8'h08};
    for (int i = 0; i < DEPTH; i++) begin
      hi = 8'h10 + 8'(i);
      lo = 8'h80 + 8'(i);
      cs = cs + hi + lo;
      tx_q.push_back(hi);
      tx_q.push_back(lo);
      exp_wr(i, {hi, lo});
    end
    tx_q.push_back(cs);
    send_bytes(0);
    wait_idle(50);
    check("t6_cs_const", 32'(cs),     32'h0000_00B8);
    check("t6_done",     32'(done),   32'd1);
    check("t6_err",      32'(err),    32'd0);
    check("t6_writes",   32'(wr_cnt - wr_base), 32'(DEPTH));
    check("t6_last_addr",  32'(d_addr),   32'h0000_0007);
    check("t6_last_data",  32'(wrt_data), 32'h0000_1787);
    check("t6_wrap_addr",  32'(d_addr2),  32'h0000_0005);
    check("t6_wrap_done",  32'(done2),    32'd1);

    check("sb_empty",  32'(exp_q.size()),  32'd0);
    check("sb2_empty", 32'(exp2_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
